// File: rtl/tof_i2c_txn_ctrl_pkg.sv
// Shared types and widths for the ToF I2C transaction controller.
package tof_i2c_txn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_START,
        ST_XFER,
        ST_DRAIN,
        ST_ABORT
    } txn_state_t;

    localparam int unsigned SLAVE_ADDR_W       = 7;
    localparam int unsigned REG_ADDR_W         = 16;
    localparam int unsigned NB_W_DEF           = 17;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1048576;

    // Watchdog counter width: holds values 0..cycles-1.
    function automatic int unsigned wd_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/tof_i2c_byte_fifo.sv
// Synchronous byte FIFO; push while full is accepted only alongside a pop.
module tof_i2c_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_eff;
    logic          pop_eff;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_eff   = pop && !empty && !flush;
    assign push_eff  = push && !flush && (!full || pop_eff);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tof_i2c_txn_ctrl.sv
// Register-level transaction sequencer in front of the I2C byte engine:
// write-byte buffering, read-byte streaming, underrun/watchdog abort.
module tof_i2c_txn_ctrl
    import tof_i2c_txn_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned NB_W           = NB_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SLAVE_ADDR_W-1:0] req_slave_addr,
    input  logic [REG_ADDR_W-1:0]   req_reg_addr,
    input  logic                    req_is_read,
    input  logic [7:0]              req_len,
    input  logic                    wr_valid,
    input  logic [7:0]              wr_data,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic [7:0]              rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    i2c_start,
    output logic                    i2c_reset,
    output logic [SLAVE_ADDR_W-1:0] i2c_slave_addr,
    output logic [REG_ADDR_W-1:0]   i2c_reg_addr,
    output logic                    i2c_is_read,
    output logic [NB_W-1:0]         i2c_nb_of_bytes,
    output logic [7:0]              i2c_data_in,
    input  logic                    i2c_ready,
    input  logic [7:0]              i2c_data_out
);

    localparam int unsigned    CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned    TO_W    = wd_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    txn_state_t      state;
    txn_state_t      state_next;
    logic            ready_q;
    logic            byte_evt;
    logic            xfer_evt;
    logic            accept;
    logic            len_zero;
    logic [7:0]      remaining;
    logic [7:0]      rem_dec;
    logic [7:0]      nb_after;
    logic            last_byte;
    logic            push_now;
    logic            underrun;
    logic            timeout;
    logic            done_set;
    logic [TO_W-1:0] wd_cnt;
    logic            abort_cnt;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign byte_evt  = i2c_ready && !ready_q;
    assign xfer_evt  = (state == ST_XFER) && byte_evt;
    assign accept    = req_valid && req_ready;
    assign len_zero  = (req_len == '0);
    assign rem_dec   = remaining - 8'd1;
    assign nb_after  = rem_dec - 8'd1;
    assign last_byte = (rem_dec == '0);
    assign push_now  = wr_valid && wr_ready;
    assign wr_ready  = !fifo_full;
    assign fifo_pop  = xfer_evt && !i2c_is_read;

    // Underrun means no byte will be at the FIFO head after this edge,
    // counting a push that lands in the same cycle as the pop.
    assign underrun = fifo_pop && !last_byte && (fifo_count <= CW'(1)) && !push_now;
    assign timeout  = ((state == ST_XFER) || (state == ST_DRAIN)) && !byte_evt
                      && (wd_cnt == WD_LAST);
    assign done_set = ((state == ST_IDLE) && accept && len_zero)
                   || ((state == ST_DRAIN) && !i2c_ready)
                   || ((state == ST_ABORT) && abort_cnt);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && !len_zero) state_next = ST_PRIME;
            ST_PRIME: if (i2c_is_read || !fifo_empty) state_next = ST_START;
            ST_START: state_next = ST_XFER;
            ST_XFER: begin
                if (timeout || underrun)     state_next = ST_ABORT;
                else if (xfer_evt && last_byte) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i2c_ready)   state_next = ST_IDLE;
                else if (timeout) state_next = ST_ABORT;
            end
            ST_ABORT: if (abort_cnt) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        i2c_start  = 1'b0;
        i2c_reset  = reset;
        fifo_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = !reset;
                busy      = 1'b0;
            end
            ST_START: i2c_start = 1'b1;
            ST_ABORT: begin
                i2c_reset  = 1'b1;
                fifo_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q         <= 1'b0;
            remaining       <= '0;
            wd_cnt          <= '0;
            abort_cnt       <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            i2c_slave_addr  <= '0;
            i2c_reg_addr    <= '0;
            i2c_is_read     <= 1'b0;
            i2c_nb_of_bytes <= '0;
        end else begin
            ready_q   <= i2c_ready;
            done      <= done_set;
            rd_valid  <= xfer_evt && i2c_is_read;
            abort_cnt <= (state == ST_ABORT) && !abort_cnt;
            if (xfer_evt && i2c_is_read) rd_data <= i2c_data_out;

            if (accept) begin
                i2c_slave_addr <= req_slave_addr;
                i2c_reg_addr   <= req_reg_addr;
                i2c_is_read    <= req_is_read;
                remaining      <= req_len;
                error          <= len_zero;
            end else if (underrun || timeout) begin
                error <= 1'b1;
            end

            if ((state == ST_PRIME) && (state_next == ST_START))
                i2c_nb_of_bytes <= NB_W'(rem_dec);
            if (xfer_evt) begin
                remaining       <= rem_dec;
                i2c_nb_of_bytes <= last_byte ? '0 : NB_W'(nb_after);
            end

            if ((state == ST_START) || byte_evt)
                wd_cnt <= '0;
            else if ((state == ST_XFER) || (state == ST_DRAIN))
                wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

    tof_i2c_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head_data (i2c_data_in),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
